// File: rtl/bus_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_decoder_pkg
// Description : Shared FSM encoding and decode constants for bus_decoder_n.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_decoder_pkg;

    localparam int          MAX_SLAVES = 16;
    localparam int          SLOT_IDX_W = $clog2(MAX_SLAVES);
    localparam logic [15:0] RAM_PAGE   = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_counter
// Description : Wait-cycle counter; expire pulses on the LIMIT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expire
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expire = i_enable && (r_count == 16'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/bus_decoder_n.sv
`default_nettype none
// ============================================================================
// Module      : bus_decoder_n
// Description : N-slot memory-mapped decoder with registered reads, wait
//               states, error responses and sticky error capture.
//               Optional define BUS_DECODER_TIMEOUT_EN adds a read timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_decoder_n
    import bus_decoder_pkg::*;
#(
    parameter int          N_SLAVES  = 8,
    parameter logic [15:0] BASE_PAGE = 16'h0040,
    parameter logic [15:0] AUTO_ACK  = 16'h0001,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             mem_addr,
    input  logic                    mem_rstrb,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wmask,
    output logic [31:0]             mem_rdata,
    output logic                    mem_rbusy,
    output logic                    mem_wbusy,
    output logic [N_SLAVES-1:0]     s_cs,
    output logic                    s_rd,
    output logic                    s_wr,
    output logic [3:0]              s_wmask,
    output logic [31:0]             s_wdata,
    input  logic [32*N_SLAVES-1:0]  s_rdata,
    input  logic [N_SLAVES-1:0]     s_ack,
    input  logic                    err_clr,
    output logic                    err_flag,
    output logic [31:0]             err_addr
);

    localparam logic [N_SLAVES-1:0] c_auto_mask = AUTO_ACK[N_SLAVES-1:0];
    localparam logic [N_SLAVES-1:0] c_slot0     = N_SLAVES'(1);

    if (N_SLAVES < 2 || N_SLAVES > MAX_SLAVES) begin : g_bad_n_slaves
        $error("bus_decoder_n: N_SLAVES out of range 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_decoder_n: TIMEOUT out of range 1..65535");
    end

    state_t                r_state;
    state_t                w_next;
    logic [N_SLAVES-1:0]   r_slot;
    logic [31:0]           r_addr;
    logic [31:0]           r_rdata;
    logic                  r_err_flag;
    logic [31:0]           r_err_addr;

    logic [15:0]           w_page;
    logic [15:0]           w_off;
    logic                  w_is_ram;
    logic                  w_in_range;
    logic                  w_mapped;
    logic [SLOT_IDX_W-1:0] w_idx;
    logic [N_SLAVES-1:0]   w_dec_cs;
    logic [31:0]           w_sel_rdata;
    logic                  w_ack;
    logic                  w_timeout;
    logic                  w_wait_entry;
    logic                  w_load_rdata;
    logic [31:0]           w_load_value;
    logic                  w_err_set;
    logic [31:0]           w_err_addr;

    // Address decode; RAM wins if BASE_PAGE were ever configured to overlap it.
    always_comb begin
        w_page     = mem_addr[31:16];
        w_off      = w_page - BASE_PAGE;
        w_is_ram   = (w_page == RAM_PAGE);
        w_in_range = (w_page >= BASE_PAGE) && (w_off < 16'(N_SLAVES - 1));
        w_mapped   = w_is_ram || w_in_range;
        w_idx      = w_is_ram ? '0 : SLOT_IDX_W'(w_off + 16'd1);
        w_dec_cs   = w_mapped ? (c_slot0 << w_idx) : '0;
    end

    // Latched one-hot selects both the return data and the ack source.
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_slot[i]) begin
                w_sel_rdata = w_sel_rdata | s_rdata[32*i +: 32];
            end
        end
        w_ack = |(r_slot & (s_ack | c_auto_mask));
    end

`ifdef BUS_DECODER_TIMEOUT_EN
    bus_timeout_counter #(
        .LIMIT    (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_wait_entry),
        .i_enable (r_state == ST_WAIT),
        .o_expire (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        s_cs         = '0;
        s_rd         = 1'b0;
        s_wr         = 1'b0;
        mem_rbusy    = 1'b0;
        w_wait_entry = 1'b0;
        w_load_rdata = 1'b0;
        w_load_value = ERR_DATA;
        w_err_set    = 1'b0;
        w_err_addr   = mem_addr;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_wmask != 4'h0) begin
                        // Writes are posted; a simultaneous read is dropped as an error.
                        s_cs = w_dec_cs;
                        s_wr = w_mapped;
                        if (!w_mapped || mem_rstrb) begin
                            w_err_set = 1'b1;
                        end
                    end else if (mem_rstrb) begin
                        if (w_mapped) begin
                            s_cs         = w_dec_cs;
                            s_rd         = 1'b1;
                            w_wait_entry = 1'b1;
                            w_next       = ST_WAIT;
                        end else begin
                            w_next = ST_ERR;
                        end
                    end
                end
                ST_WAIT: begin
                    s_cs      = r_slot;
                    mem_rbusy = 1'b1;
                    if (w_ack) begin
                        w_load_rdata = 1'b1;
                        w_load_value = w_sel_rdata;
                        w_next       = ST_IDLE;
                    end else if (w_timeout) begin
                        w_load_rdata = 1'b1;
                        w_err_set    = 1'b1;
                        w_err_addr   = r_addr;
                        w_next       = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    mem_rbusy    = 1'b1;
                    w_load_rdata = 1'b1;
                    w_err_set    = 1'b1;
                    w_err_addr   = r_addr;
                    w_next       = ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_slot     <= '0;
            r_addr     <= '0;
            r_rdata    <= '0;
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_wait_entry) begin
                r_slot <= w_dec_cs;
            end
            if (r_state == ST_IDLE && mem_rstrb) begin
                r_addr <= mem_addr;
            end
            if (w_load_rdata) begin
                r_rdata <= w_load_value;
            end
            // A new error beats a same-cycle clear and re-arms the address capture.
            if (w_err_set) begin
                r_err_flag <= 1'b1;
                if (!r_err_flag || err_clr) begin
                    r_err_addr <= w_err_addr;
                end
            end else if (err_clr) begin
                r_err_flag <= 1'b0;
            end
        end
    end

    assign s_wmask   = (|s_cs) ? mem_wmask : 4'h0;
    assign s_wdata   = mem_wdata;
    assign mem_wbusy = 1'b0;
    assign mem_rdata = r_rdata;
    assign err_flag  = r_err_flag;
    assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: doc/bus_decoder_n.md
Name: bus_decoder_n

Overview:
Parametrised memory-mapped interconnect between the FemtoRV32 data port and N peripheral slots.
- Replaces the fixed 7-way chip-select and the combinational read mux of the SoC top.
- Adds a registered read path, per-slot acknowledge with wait states on mem_rbusy, and error responses for unmapped addresses.
- Adds a sticky error/status capture.
- Slot 0 is program RAM. Slots 1..N_SLAVES-1 are 64 KiB pages starting at BASE_PAGE.

Parameters:
- N_SLAVES, 8: slot count, 2..16; slot 0 is RAM.
- BASE_PAGE, 16'h0040: mem_addr[31:16] of slot 1; slot i maps to page BASE_PAGE+i-1.
- AUTO_ACK, 16'h0001: bit i set means slot i is zero-wait; the decoder generates its ack internally one cycle after the request.
- TIMEOUT, 255: maximum wait cycles for a slave ack, 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  32  CPU address.
- mem_rstrb  in  1  CPU read strobe, one-cycle pulse.
- mem_wdata  in  32  CPU write data.
- mem_wmask  in  4  CPU byte write mask; nonzero means write.
- mem_rdata  out  32  registered read data to CPU.
- mem_rbusy  out  1  read wait to CPU.
- mem_wbusy  out  1  write wait to CPU; always 0 because writes are posted.
- s_cs  out  N_SLAVES  one-hot slot select.
- s_rd  out  1  read pulse to slaves.
- s_wr  out  1  write pulse to slaves.
- s_wmask  out  4  mem_wmask gated by any s_cs.
- s_wdata  out  32  mem_wdata passthrough.
- s_rdata  in  32*N_SLAVES  flattened slave read data; slot i occupies bits [32i+31:32i].
- s_ack  in  N_SLAVES  per-slot read acknowledge, one-cycle pulse.
- err_clr  in  1  clears the sticky error status.
- err_flag  out  1  sticky error indicator.
- err_addr  out  32  address of the first error since the last clear.

Behaviour:
- Reset values (synchronous, active-high reset, single clock clk): state IDLE, mem_rdata 0, err_flag 0, err_addr 0, internal wait counter 0. All outputs are 0.
- Decode: page = mem_addr[31:16].
  - Page 16'h0000 selects slot 0.
  - BASE_PAGE <= page < BASE_PAGE+N_SLAVES-1 selects slot page-BASE_PAGE+1.
  - Every other page is unmapped.
- States: IDLE, WAIT, ERR.
- IDLE:
  - Write (mem_wmask != 0) to a mapped page: s_cs one-hot and s_wr=1 combinationally in the same cycle. State stays IDLE; there is no wait.
  - Write to an unmapped page: s_cs=0, the write is dropped, err_flag set, err_addr captured.
  - Read (mem_rstrb) to a mapped page: s_cs and s_rd asserted in that cycle (cycle T). Slot index is latched; go to WAIT.
  - Read to an unmapped page: no s_cs; go to ERR.
  - mem_rstrb and nonzero mem_wmask in the same cycle: the write is performed, the read is dropped, err_flag is set.
- WAIT:
  - s_cs holds the latched one-hot; s_rd=0; mem_rbusy=1.
  - Ack source is s_ack[slot], or the internal ack at T+1 for AUTO_ACK slots.
  - On ack in cycle k: mem_rdata <= s_rdata[slot] and go to IDLE. mem_rbusy falls at k+1, and mem_rdata is valid from k+1.
  - Minimum read latency: data at T+2.
  - The CPU issues no new request while mem_rbusy=1. Any such request is ignored.
- ERR: one cycle with mem_rbusy=1. Then mem_rdata <= ERR_DATA, err_flag set, go to IDLE.
- Hold and ack rules:
  - mem_rdata holds between reads.
  - s_ack for a non-latched slot is ignored.
  - s_ack received in IDLE is ignored.
- Error status:
  - err_addr captures only while err_flag=0.
  - err_clr clears err_flag. If err_clr and a new error occur in the same cycle, the error wins: flag stays set and err_addr loads the new address.
- Reset during WAIT: next cycle is IDLE, mem_rbusy=0, s_cs=0; a late ack is ignored.

Optional Feature:
BUS_DECODER_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If it reaches TIMEOUT cycles without an ack, the block behaves as ERR: mem_rdata=ERR_DATA, err_flag set, err_addr = latched address, return to IDLE. The counter clears on entry to WAIT.
- Undefined: no counter; WAIT persists until ack or reset.

Decomposition:
- Package bus_decoder_pkg: state encoding, RAM_PAGE=16'h0000, and a clog2-based slot-index width constant.
- Sub-module bus_timeout_counter: load/enable/expire, instantiated only under BUS_DECODER_TIMEOUT_EN.
- Decode, FSM and read register stay in bus_decoder_n.

Test Plan:
1. AUTO_ACK bit0=1, s_rdata slot0=32'h1234_5678, rstrb at 0x0000_0010 (cycle T) -> s_cs=8'h01 and s_rd at T; mem_rbusy=1 at T+1, 0 at T+2; mem_rdata=32'h1234_5678 at T+2.
2. Read 0x0042_0004 (slot 3), s_ack[3] pulsed 5 cycles after the request, s_rdata slot3=32'hA5A5_0003 -> mem_rbusy high 5 cycles; mem_rdata=32'hA5A5_0003 the cycle after the ack; s_cs=8'h08 throughout.
3. Read 0x0090_0000 -> s_cs=0; mem_rbusy high 1 cycle; mem_rdata=32'hDEAD_BEEF; err_flag=1; err_addr=32'h0090_0000. Then err_clr -> err_flag=0.
4. BUS_DECODER_TIMEOUT_EN defined, TIMEOUT=8, read slot 2 with no ack -> mem_rbusy high 8 cycles; then mem_rdata=ERR_DATA, err_flag=1.
5. Write 0x0040_0000, mem_wmask=4'hF, mem_wdata=32'h41 -> same cycle s_cs=8'h02, s_wr=1, s_wmask=4'hF; mem_wbusy=0; state stays IDLE.
6. Reset asserted 2 cycles into a slot-4 WAIT, then s_ack[4] pulsed -> next cycle IDLE, mem_rbusy=0, s_cs=0, mem_rdata=0; the ack has no effect.
